// File: rtl/dma32_pkg.sv
// Shared definitions for the 32-bit ESP DMA responder: field widths,
// transfer size encodings, FSM states and the request sanity check.
package dma32_pkg;

    localparam int DMA_INDEX_W  = 32;
    localparam int DMA_LENGTH_W = 32;
    localparam int DMA_SIZE_W   = 3;
    localparam int DMA_USER_W   = 5;

    localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_BYTE  = 3'b000;
    localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_HWORD = 3'b001;
    localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_WORD  = 3'b010;
    localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } dma_state_e;

    // A request is flagged when it is not word sized or when it runs past the
    // end of memory; the span is formed at 33 bits so it cannot overflow.
    function automatic logic req_is_bad(input logic [DMA_SIZE_W-1:0]   size,
                                        input logic [DMA_INDEX_W-1:0]  index,
                                        input logic [DMA_LENGTH_W-1:0] length,
                                        input int unsigned             words);
        logic [32:0] span;
        span = {1'b0, index} + {1'b0, length};
        return (size != DMA_SIZE_WORD) || (span > 33'(words));
    endfunction

endpackage

// File: rtl/dma32_resp_mem.sv
// Single-port synchronous word RAM with a one-cycle registered read.
// The read register only updates on a read access, so it holds its value
// otherwise; it clears on reset so the data outputs start at zero.
module dma32_resp_mem #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [WORDS];

    // Write port: memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: registered data, updated only on a read access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dma32_mem_responder.sv
// Memory-side responder for the 32-bit ESP accelerator DMA interface.
// Serves read bursts from and absorbs write bursts into an internal RAM,
// with a backdoor port for preload/readback while the engine is idle.
module dma32_mem_responder
    import dma32_pkg::*;
#(
    parameter int    MEM_WORDS = 1024,
    parameter int    READ_LAT  = 2,
    localparam int   ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    dma_read_ctrl_valid,
    output logic                    dma_read_ctrl_ready,
    input  logic [DMA_INDEX_W-1:0]  dma_read_ctrl_data_index,
    input  logic [DMA_LENGTH_W-1:0] dma_read_ctrl_data_length,
    input  logic [DMA_SIZE_W-1:0]   dma_read_ctrl_data_size,
    input  logic [DMA_USER_W-1:0]   dma_read_ctrl_data_user,

    output logic                    dma_read_chnl_valid,
    input  logic                    dma_read_chnl_ready,
    output logic [31:0]             dma_read_chnl_data,

    input  logic                    dma_write_ctrl_valid,
    output logic                    dma_write_ctrl_ready,
    input  logic [DMA_INDEX_W-1:0]  dma_write_ctrl_data_index,
    input  logic [DMA_LENGTH_W-1:0] dma_write_ctrl_data_length,
    input  logic [DMA_SIZE_W-1:0]   dma_write_ctrl_data_size,
    input  logic [DMA_USER_W-1:0]   dma_write_ctrl_data_user,

    input  logic                    dma_write_chnl_valid,
    output logic                    dma_write_chnl_ready,
    input  logic [31:0]             dma_write_chnl_data,

    input  logic                    bd_en,
    input  logic                    bd_we,
    input  logic [ADDR_W-1:0]       bd_addr,
    input  logic [31:0]             bd_wdata,
    output logic [31:0]             bd_rdata,

    output logic                    busy,
    output logic                    err
);

    dma_state_e  state;
    dma_state_e  state_next;

    logic [31:0] base_index;
    logic [31:0] beat_len;
    logic [31:0] beat_cnt;
    logic [31:0] wait_cnt;
    logic        err_q;

    logic        rd_ctrl_hs;
    logic        wr_ctrl_hs;
    logic        rd_chnl_hs;
    logic        wr_chnl_hs;
    logic        last_beat;
    logic        wait_done;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic unused_user;
    assign unused_user = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user};

    // A read request takes priority, so the write ctrl ready drops while a
    // read is being offered and the write request stays pending.
    assign dma_read_ctrl_ready  = (state == IDLE);
    assign dma_write_ctrl_ready = (state == IDLE) && !dma_read_ctrl_valid;
    assign dma_read_chnl_valid  = (state == RD_BURST);
    assign dma_write_chnl_ready = (state == WR_BURST);
    assign dma_read_chnl_data   = (state == RD_BURST) ? ram_rdata : '0;
    assign bd_rdata             = ram_rdata;
    assign busy                 = (state != IDLE);
    assign err                  = err_q;

    assign rd_ctrl_hs = dma_read_ctrl_valid  && dma_read_ctrl_ready;
    assign wr_ctrl_hs = dma_write_ctrl_valid && dma_write_ctrl_ready;
    assign rd_chnl_hs = dma_read_chnl_valid  && dma_read_chnl_ready;
    assign wr_chnl_hs = dma_write_chnl_valid && dma_write_chnl_ready;
    assign last_beat  = (beat_cnt == beat_len - 32'd1);
    assign wait_done  = (wait_cnt == 32'(READ_LAT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; zero-length requests are accepted without leaving IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rd_ctrl_hs) begin
                    if (dma_read_ctrl_data_length != '0) begin
                        state_next = RD_WAIT;
                    end
                end else if (wr_ctrl_hs) begin
                    if (dma_write_ctrl_data_length != '0) begin
                        state_next = WR_BURST;
                    end
                end
            end
            RD_WAIT: begin
                if (wait_done) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                if (rd_chnl_hs && last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_BURST: begin
                if (wr_chnl_hs && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency/beat counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_index <= '0;
            beat_len   <= '0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_ctrl_hs) begin
                        base_index <= dma_read_ctrl_data_index;
                        beat_len   <= dma_read_ctrl_data_length;
                        beat_cnt   <= '0;
                        wait_cnt   <= '0;
                        if (req_is_bad(dma_read_ctrl_data_size, dma_read_ctrl_data_index,
                                       dma_read_ctrl_data_length, MEM_WORDS)) begin
                            err_q <= 1'b1;
                        end
                    end else if (wr_ctrl_hs) begin
                        base_index <= dma_write_ctrl_data_index;
                        beat_len   <= dma_write_ctrl_data_length;
                        beat_cnt   <= '0;
                        wait_cnt   <= '0;
                        if (req_is_bad(dma_write_ctrl_data_size, dma_write_ctrl_data_index,
                                       dma_write_ctrl_data_length, MEM_WORDS)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
                RD_BURST: begin
                    if (rd_chnl_hs) begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                WR_BURST: begin
                    if (wr_chnl_hs) begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM port arbitration: the backdoor owns the port in IDLE; otherwise the
    // burst engine prefetches beat 0 in the last wait cycle and the next beat
    // on each read handshake. Reset blocks any access on its edge.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    ram_en    = bd_en;
                    ram_we    = bd_we;
                    ram_addr  = bd_addr;
                    ram_wdata = bd_wdata;
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        ram_en   = 1'b1;
                        ram_addr = ADDR_W'(base_index);
                    end
                end
                RD_BURST: begin
                    if (rd_chnl_hs && !last_beat) begin
                        ram_en   = 1'b1;
                        ram_addr = ADDR_W'(base_index + beat_cnt + 32'd1);
                    end
                end
                WR_BURST: begin
                    if (wr_chnl_hs) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = ADDR_W'(base_index + beat_cnt);
                        ram_wdata = dma_write_chnl_data;
                    end
                end
                default: ;
            endcase
        end
    end

    dma32_resp_mem #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dma32_mem_responder.sv
// Bench for dma32_mem_responder: directed scenarios with literal expectations
// plus a transaction-level memory model checked every cycle.
module tb_dma32_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int READ_LAT  = 2;
    localparam int ADDR_W    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        dma_read_ctrl_valid        = 1'b0;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index   = '0;
    logic [31:0] dma_read_ctrl_data_length  = '0;
    logic [2:0]  dma_read_ctrl_data_size    = 3'b010;
    logic [4:0]  dma_read_ctrl_data_user    = '0;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready        = 1'b1;
    logic [31:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid       = 1'b0;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index  = '0;
    logic [31:0] dma_write_ctrl_data_length = '0;
    logic [2:0]  dma_write_ctrl_data_size   = 3'b010;
    logic [4:0]  dma_write_ctrl_data_user   = '0;
    logic        dma_write_chnl_valid       = 1'b0;
    logic        dma_write_chnl_ready;
    logic [31:0] dma_write_chnl_data        = '0;
    logic        bd_en    = 1'b0;
    logic        bd_we    = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [31:0] bd_wdata = '0;
    logic [31:0] bd_rdata;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    dma32_mem_responder #(.MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_ctrl_data_user(dma_read_ctrl_data_user),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_ctrl_data_user(dma_write_ctrl_data_user),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .bd_en(bd_en), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int fails  = 0;

    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] wq [$];
    logic        model_err = 1'b0;
    logic        started   = 1'b0;
    logic        bd_pend   = 1'b0;
    logic [31:0] bd_exp    = '0;
    logic        stalled   = 1'b0;
    logic [31:0] held      = '0;
    logic [31:0] wr_addr   = '0;
    int          wr_left   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level model and per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (started) check_output("err_vs_model", 32'(err), 32'(model_err));
            started   = 1'b1;
            exp_q.delete();
            wr_left   = 0;
            model_err = 1'b0;
            bd_pend   = 1'b0;
            stalled   = 1'b0;
        end else if (started) begin
            check_output("err_vs_model", 32'(err), 32'(model_err));
            if (bd_pend) check_output("bd_rdata_vs_model", bd_rdata, bd_exp);
            bd_pend = !busy && bd_en && !bd_we;
            bd_exp  = model_mem[bd_addr];
            if (dma_read_chnl_valid) begin
                if (stalled) check_output("rd_hold_stable", dma_read_chnl_data, held);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL rd_unexpected_beat: got valid=1 data=0x%08h, expected valid=0",
                             dma_read_chnl_data);
                end else begin
                    check_output("rd_beat_vs_model", dma_read_chnl_data, exp_q[0]);
                    if (dma_read_chnl_ready) exp_q.pop_front();
                end
            end
            stalled = dma_read_chnl_valid && !dma_read_chnl_ready;
            held    = dma_read_chnl_data;
            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                for (int n = 0; n < int'(dma_read_ctrl_data_length) && n < 256; n++)
                    exp_q.push_back(model_mem[(dma_read_ctrl_data_index + 32'(n)) % MEM_WORDS]);
                if (dma_read_ctrl_data_size != 3'b010 ||
                    ({32'd0, dma_read_ctrl_data_index} + {32'd0, dma_read_ctrl_data_length}) > 64'd1024)
                    model_err = 1'b1;
            end
            if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
                wr_addr = dma_write_ctrl_data_index;
                wr_left = int'(dma_write_ctrl_data_length);
                if (dma_write_ctrl_data_size != 3'b010 ||
                    ({32'd0, dma_write_ctrl_data_index} + {32'd0, dma_write_ctrl_data_length}) > 64'd1024)
                    model_err = 1'b1;
            end
            if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                if (wr_left == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL wr_unexpected_beat: got ready=1, expected ready=0");
                end else begin
                    model_mem[wr_addr % MEM_WORDS] = dma_write_chnl_data;
                    wr_addr = wr_addr + 32'd1;
                    wr_left--;
                end
            end
            if (!busy && bd_en && bd_we) model_mem[bd_addr] = bd_wdata;
        end
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bd_en = 1'b1; bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(posedge clk); #1;
        bd_en = 1'b0; bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        bd_en = 1'b1; bd_we = 1'b0; bd_addr = a;
        @(posedge clk); #1;
        bd_en = 1'b0;
        @(negedge clk);
        d = bd_rdata;
        @(posedge clk); #1;
    endtask

    task automatic issue_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size);
        int cyc;
        cyc = 0;
        dma_read_ctrl_valid = 1'b1; dma_read_ctrl_data_index = idx;
        dma_read_ctrl_data_length = len; dma_read_ctrl_data_size = size;
        @(negedge clk);
        while (!dma_read_ctrl_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("rd_ctrl_accept", 32'(dma_read_ctrl_ready), 32'd1);
        @(posedge clk); #1;
        dma_read_ctrl_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size);
        int cyc;
        cyc = 0;
        dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = idx;
        dma_write_ctrl_data_length = len; dma_write_ctrl_data_size = size;
        @(negedge clk);
        while (!dma_write_ctrl_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("wr_ctrl_accept", 32'(dma_write_ctrl_ready), 32'd1);
        @(posedge clk); #1;
        dma_write_ctrl_valid = 1'b0;
    endtask

    task automatic send_beats(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data  = wq.pop_front();
            @(negedge clk);
            while (!dma_write_chnl_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check_output("wr_chnl_accept", 32'(dma_write_chnl_ready), 32'd1);
            @(posedge clk); #1;
        end
        dma_write_chnl_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the ctrl handshake.
    task automatic collect_read(input int n, input bit rnd, output int first_lat);
        int cyc;
        cyc = 0;
        first_lat = -1;
        got_q.delete();
        while (got_q.size() < n && cyc < 300) begin
            dma_read_chnl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (dma_read_chnl_valid && first_lat < 0) first_lat = cyc;
            if (dma_read_chnl_valid && dma_read_chnl_ready) got_q.push_back(dma_read_chnl_data);
            @(posedge clk); #1;
        end
        dma_read_chnl_ready = 1'b1;
        check_output("rd_beat_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic check_reset_values();
        check_output("rst_rd_ctrl_ready", 32'(dma_read_ctrl_ready), 32'd1);
        check_output("rst_wr_ctrl_ready", 32'(dma_write_ctrl_ready), 32'd1);
        check_output("rst_rd_chnl_valid", 32'(dma_read_chnl_valid), 32'd0);
        check_output("rst_rd_chnl_data", dma_read_chnl_data, 32'd0);
        check_output("rst_wr_chnl_ready", 32'(dma_write_chnl_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_bd_rdata", bd_rdata, 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : apply_stimulus
        int lat, cyc, beats, hs_cyc;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;

        // Preload and read back through the read channel.
        for (int i = 0; i < 16; i++) bd_write(ADDR_W'(i), 32'hA000 + 32'(i));
        issue_read(32'd4, 32'd8, 3'b010);
        collect_read(8, 1'b0, lat);
        check_output("rd_first_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check_output("rd_preload_beat", got_q[i], 32'hA004 + 32'(i));
        @(negedge clk);
        check_output("rd_preload_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Write burst, ready timing, then backdoor readback.
        issue_write(32'd100, 32'd4, 3'b010);
        @(negedge clk);
        check_output("wr_chnl_ready_after_ctrl", 32'(dma_write_chnl_ready), 32'd1);
        @(posedge clk); #1;
        wq = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_beats(4);
        @(negedge clk);
        check_output("wr_done_rd_ctrl_ready", 32'(dma_read_ctrl_ready), 32'd1);
        check_output("wr_done_wr_ctrl_ready", 32'(dma_write_ctrl_ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bd_read(ADDR_W'(100 + i), d);
            check_output("wr_readback", d, 32'h11 * 32'(i + 1));
        end

        // Backpressure on the read channel.
        issue_read(32'd0, 32'd6, 3'b010);
        collect_read(6, 1'b1, lat);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check_output("rd_backpressure_beat", got_q[i], 32'hA000 + 32'(i));

        // Simultaneous read and write requests: read wins, write waits.
        dma_read_ctrl_valid = 1'b1; dma_read_ctrl_data_index = 32'd0;
        dma_read_ctrl_data_length = 32'd3; dma_read_ctrl_data_size = 3'b010;
        dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = 32'd200;
        dma_write_ctrl_data_length = 32'd2; dma_write_ctrl_data_size = 3'b010;
        @(negedge clk);
        check_output("sim_rd_ctrl_ready", 32'(dma_read_ctrl_ready), 32'd1);
        check_output("sim_wr_ctrl_ready", 32'(dma_write_ctrl_ready), 32'd0);
        @(posedge clk); #1;
        dma_read_ctrl_valid = 1'b0;
        cyc = 0; beats = 0; hs_cyc = -1;
        while (hs_cyc < 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (dma_read_chnl_valid && dma_read_chnl_ready) beats++;
            if (dma_write_ctrl_valid && dma_write_ctrl_ready) hs_cyc = cyc;
            @(posedge clk); #1;
        end
        dma_write_ctrl_valid = 1'b0;
        check_output("sim_wr_accept_cycle", 32'(hs_cyc), 32'd6);
        check_output("sim_rd_beats_first", 32'(beats), 32'd3);
        wq = '{32'h77, 32'h88};
        send_beats(2);
        bd_read(ADDR_W'(200), d);
        check_output("sim_wr_readback0", d, 32'h77);
        bd_read(ADDR_W'(201), d);
        check_output("sim_wr_readback1", d, 32'h88);

        // Address wrap past the top of memory raises err.
        bd_write(ADDR_W'(1022), 32'hBEEF03FE);
        bd_write(ADDR_W'(1023), 32'hBEEF03FF);
        issue_read(32'd1022, 32'd4, 3'b010);
        collect_read(4, 1'b0, lat);
        if (got_q.size() == 4) begin
            check_output("wrap_beat0", got_q[0], 32'hBEEF03FE);
            check_output("wrap_beat1", got_q[1], 32'hBEEF03FF);
            check_output("wrap_beat2", got_q[2], 32'hA000);
            check_output("wrap_beat3", got_q[3], 32'hA001);
        end
        @(negedge clk);
        check_output("wrap_err", 32'(err), 32'd1);
        @(posedge clk); #1;

        // Illegal size raises err but is still serviced.
        pulse_reset();
        @(negedge clk);
        check_output("err_cleared_by_rst", 32'(err), 32'd0);
        @(posedge clk); #1;
        issue_read(32'd5, 32'd1, 3'b011);
        collect_read(1, 1'b0, lat);
        if (got_q.size() == 1) check_output("bad_size_beat", got_q[0], 32'hA005);
        @(negedge clk);
        check_output("bad_size_err", 32'(err), 32'd1);
        @(posedge clk); #1;

        // Zero-length read: no beats, never busy.
        pulse_reset();
        issue_read(32'd0, 32'd0, 3'b010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("len0_busy", 32'(busy), 32'd0);
            check_output("len0_rd_valid", 32'(dma_read_chnl_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a write burst.
        bd_write(ADDR_W'(302), 32'h5555);
        issue_write(32'd300, 32'd5, 3'b010);
        wq = '{32'hC0, 32'hC1};
        send_beats(2);
        dma_write_chnl_valid = 1'b1;
        dma_write_chnl_data  = 32'hC2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dma_write_chnl_valid = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        bd_read(ADDR_W'(300), d);
        check_output("rst_mid_word0", d, 32'hC0);
        bd_read(ADDR_W'(301), d);
        check_output("rst_mid_word1", d, 32'hC1);
        bd_read(ADDR_W'(302), d);
        check_output("rst_mid_word2_untouched", d, 32'h5555);

        repeat (3) @(posedge clk);
        #1;
        check_output("rd_model_drained", 32'(exp_q.size()), 32'd0);
        check_output("wr_model_drained", 32'(wr_left), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
